clock_mode_ctrl: RTL and testbench

- Control and timekeeping core of the multi-mode clock.
- Holds running time and alarm time as binary h/m/s registers.
- Runs the RUN / SET_TIME / SET_ALARM mode FSM from debounced button pulses and raises the alarm.
- Drives the digit displayer directly: cur_time, per-field flash levels and the alarming level.

---
 rtl/clock_pkg.sv | 30 +++
 rtl/hms_counter.sv | 55 +++++
 rtl/clock_mode_ctrl.sv | 147 ++++++++++++++
 tb/tb_clock_mode_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared types and limits for the multi-mode clock core.
package clock_pkg;

   typedef enum logic [1:0] {
      RUN       = 2'd0,
      SET_TIME  = 2'd1,
      SET_ALARM = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      HOUR = 2'd0,
      MIN  = 2'd1,
      SEC  = 2'd2
   } field_t;

   localparam logic [7:0] SEC_MAX  = 8'd59;
   localparam logic [7:0] MIN_MAX  = 8'd59;
   localparam logic [7:0] HOUR_MAX = 8'd23;

   typedef struct packed {
      logic [7:0] hour;
      logic [7:0] minute;
      logic [7:0] second;
   } hms_t;

   function automatic logic [7:0] wrap_inc(input logic [7:0] value, input logic [7:0] max);
      return (value >= max) ? 8'd0 : value + 8'd1;
   endfunction

endpackage

// File: rtl/hms_counter.sv
// One h/m/s register with full-carry tick and per-field wrapping increment.
// Exposes the next-state value so the owner can register displays in the same edge.
module hms_counter
   import clock_pkg::*;
(
   input  logic   clk,
   input  logic   rst_n,
   input  logic   tick,
   input  logic   inc_en,
   input  field_t inc_field,
   output hms_t   nxt
);

   hms_t q_r;
   hms_t nxt_s;

   // next value: tick carries across fields, increment wraps inside one field
   always_comb begin
      nxt_s = q_r;
      if (tick) begin
         nxt_s.second = wrap_inc(q_r.second, SEC_MAX);
         if (q_r.second == SEC_MAX) begin
            nxt_s.minute = wrap_inc(q_r.minute, MIN_MAX);
            if (q_r.minute == MIN_MAX) begin
               nxt_s.hour = wrap_inc(q_r.hour, HOUR_MAX);
            end else begin
               nxt_s.hour = q_r.hour;
            end
         end else begin
            nxt_s.minute = q_r.minute;
         end
      end else if (inc_en) begin
         case (inc_field)
            HOUR:    nxt_s.hour   = wrap_inc(q_r.hour, HOUR_MAX);
            MIN:     nxt_s.minute = wrap_inc(q_r.minute, MIN_MAX);
            SEC:     nxt_s.second = wrap_inc(q_r.second, SEC_MAX);
            default: nxt_s = q_r;
         endcase
      end else begin
         nxt_s = q_r;
      end
   end

   // value register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_r <= hms_t'(24'd0);
      end else begin
         q_r <= nxt_s;
      end
   end

   assign nxt = nxt_s;

endmodule

// File: rtl/clock_mode_ctrl.sv
// Mode FSM, alarm timer and registered display outputs of the multi-mode clock.
module clock_mode_ctrl
   import clock_pkg::*;
#(
   parameter int unsigned ALARM_SECS = 30
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        tick_1hz,
   input  logic        btn_mode,
   input  logic        btn_next,
   input  logic        btn_inc,
   output logic [23:0] cur_time,
   output logic        hour_flash,
   output logic        minute_flash,
   output logic        second_flash,
   output logic        alarming,
   output logic [1:0]  mode
);

   localparam logic [7:0] ALARM_INIT = 8'(ALARM_SECS);

   state_t      state_r, state_nxt_s;
   field_t      field_r, field_nxt_s;
   logic        armed_r, armed_nxt_s;
   logic [7:0]  alarm_cnt_r, alarm_cnt_nxt_s;
   logic        alarming_r, alarming_nxt_s;
   logic        cancel_s, tick_time_s, inc_time_s, inc_alarm_s, trigger_s;
   hms_t        time_nxt_s, alarm_nxt_s;
   logic [23:0] cur_time_r;
   logic        hour_flash_r, minute_flash_r, second_flash_r;
   logic [1:0]  mode_r;

   // a button while alarming only silences the alarm
   assign cancel_s    = alarming_r & (btn_mode | btn_next | btn_inc);
   assign tick_time_s = tick_1hz & (state_r != SET_TIME);

   hms_counter u_time (
      .clk       (clk),
      .rst_n     (rst_n),
      .tick      (tick_time_s),
      .inc_en    (inc_time_s),
      .inc_field (field_r),
      .nxt       (time_nxt_s)
   );

   hms_counter u_alarm (
      .clk       (clk),
      .rst_n     (rst_n),
      .tick      (1'b0),
      .inc_en    (inc_alarm_s),
      .inc_field (field_r),
      .nxt       (alarm_nxt_s)
   );

   // button decode with mode > next > inc priority
   always_comb begin
      state_nxt_s = state_r;
      field_nxt_s = field_r;
      armed_nxt_s = armed_r;
      inc_time_s  = 1'b0;
      inc_alarm_s = 1'b0;
      if (cancel_s) begin
         state_nxt_s = state_r;
      end else if (btn_mode) begin
         field_nxt_s = HOUR;
         case (state_r)
            RUN:       state_nxt_s = SET_TIME;
            SET_TIME:  state_nxt_s = SET_ALARM;
            SET_ALARM: begin
               state_nxt_s = RUN;
               armed_nxt_s = 1'b1;
            end
            default:   state_nxt_s = RUN;
         endcase
      end else if (btn_next) begin
         if (state_r != RUN) begin
            case (field_r)
               HOUR:    field_nxt_s = MIN;
               MIN:     field_nxt_s = SEC;
               default: field_nxt_s = HOUR;
            endcase
         end else begin
            field_nxt_s = field_r;
         end
      end else if (btn_inc) begin
         inc_time_s  = (state_r == SET_TIME);
         inc_alarm_s = (state_r == SET_ALARM);
      end else begin
         state_nxt_s = state_r;
      end
   end

   // alarm start, countdown and cancel
   always_comb begin
      alarming_nxt_s  = alarming_r;
      alarm_cnt_nxt_s = alarm_cnt_r;
      trigger_s = (state_r == RUN) && armed_r && tick_1hz && (time_nxt_s == alarm_nxt_s);
      if (cancel_s) begin
         alarming_nxt_s  = 1'b0;
         alarm_cnt_nxt_s = 8'd0;
      end else if (trigger_s) begin
         alarming_nxt_s  = 1'b1;
         alarm_cnt_nxt_s = ALARM_INIT;
      end else if (alarming_r && tick_1hz) begin
         alarm_cnt_nxt_s = alarm_cnt_r - 8'd1;
         alarming_nxt_s  = (alarm_cnt_r != 8'd1);
      end else begin
         alarming_nxt_s  = alarming_r;
      end
   end

   // control state and display registers, all loaded from next-state values
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r        <= RUN;
         field_r        <= HOUR;
         armed_r        <= 1'b0;
         alarm_cnt_r    <= 8'd0;
         alarming_r     <= 1'b0;
         cur_time_r     <= 24'd0;
         hour_flash_r   <= 1'b0;
         minute_flash_r <= 1'b0;
         second_flash_r <= 1'b0;
         mode_r         <= 2'd0;
      end else begin
         state_r        <= state_nxt_s;
         field_r        <= field_nxt_s;
         armed_r        <= armed_nxt_s;
         alarm_cnt_r    <= alarm_cnt_nxt_s;
         alarming_r     <= alarming_nxt_s;
         cur_time_r     <= (state_nxt_s == SET_ALARM) ? alarm_nxt_s : time_nxt_s;
         hour_flash_r   <= (state_nxt_s != RUN) && (field_nxt_s == HOUR);
         minute_flash_r <= (state_nxt_s != RUN) && (field_nxt_s == MIN);
         second_flash_r <= (state_nxt_s != RUN) && (field_nxt_s == SEC);
         mode_r         <= state_nxt_s;
      end
   end

   assign cur_time     = cur_time_r;
   assign hour_flash   = hour_flash_r;
   assign minute_flash = minute_flash_r;
   assign second_flash = second_flash_r;
   assign alarming     = alarming_r;
   assign mode         = mode_r;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Bench for clock_mode_ctrl: directed scenarios plus random buttons/ticks
// against a seconds-of-day reference model.
module tb_clock_mode_ctrl;

   localparam int unsigned ALARM_SECS = 3;

   logic        clk, rst_n, tick_1hz, btn_mode, btn_next, btn_inc;
   logic [23:0] cur_time;
   logic        hour_flash, minute_flash, second_flash, alarming;
   logic [1:0]  mode;

   int err_cnt = 0;
   int chk_cnt = 0;

   // reference model: time as seconds of day, alarm as h/m/s
   int m_secs, a_h, a_m, a_s, m_mode, m_field, m_cnt;
   bit m_armed, m_alarming;

   clock_mode_ctrl #(.ALARM_SECS(ALARM_SECS)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .tick_1hz     (tick_1hz),
      .btn_mode     (btn_mode),
      .btn_next     (btn_next),
      .btn_inc      (btn_inc),
      .cur_time     (cur_time),
      .hour_flash   (hour_flash),
      .minute_flash (minute_flash),
      .second_flash (second_flash),
      .alarming     (alarming),
      .mode         (mode)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_secs = 0; a_h = 0; a_m = 0; a_s = 0;
      m_mode = 0; m_field = 0; m_cnt = 0;
      m_armed = 1'b0; m_alarming = 1'b0;
   endtask

   function automatic logic [23:0] model_cur();
      int h, mi, s;
      if (m_mode == 2) begin
         h = a_h; mi = a_m; s = a_s;
      end else begin
         h = m_secs / 3600; mi = (m_secs / 60) % 60; s = m_secs % 60;
      end
      return {8'(h), 8'(mi), 8'(s)};
   endfunction

   function automatic logic [2:0] model_flash();
      if (m_mode == 0) return 3'b000;
      return 3'b100 >> m_field;
   endfunction

   task automatic model_step(input bit t, input bit bm, input bit bn, input bit bi);
      int st, h, mi, s;
      bit cancel;
      st = m_mode;
      cancel = m_alarming && (bm || bn || bi);
      if (cancel) begin
         m_alarming = 1'b0;
         m_cnt = 0;
      end else if (bm) begin
         m_mode = (m_mode + 1) % 3;
         m_field = 0;
         if (st == 2) m_armed = 1'b1;
      end else if (bn) begin
         if (st != 0) m_field = (m_field + 1) % 3;
      end else if (bi) begin
         if (st == 1) begin
            h = m_secs / 3600; mi = (m_secs / 60) % 60; s = m_secs % 60;
            if (m_field == 0) h = (h + 1) % 24;
            else if (m_field == 1) mi = (mi + 1) % 60;
            else s = (s + 1) % 60;
            m_secs = h * 3600 + mi * 60 + s;
         end else if (st == 2) begin
            if (m_field == 0) a_h = (a_h + 1) % 24;
            else if (m_field == 1) a_m = (a_m + 1) % 60;
            else a_s = (a_s + 1) % 60;
         end
      end
      if (t && st != 1) m_secs = (m_secs + 1) % 86400;
      if (!cancel) begin
         if (st == 0 && m_armed && t && m_secs == a_h * 3600 + a_m * 60 + a_s) begin
            m_alarming = 1'b1;
            m_cnt = ALARM_SECS;
         end else if (m_alarming && t) begin
            m_cnt--;
            if (m_cnt == 0) m_alarming = 1'b0;
         end
      end
   endtask

   task automatic check_outputs();
      check_val("cur_time", cur_time, model_cur());
      check_val("mode", mode, m_mode);
      check_val("flash", {hour_flash, minute_flash, second_flash}, model_flash());
      check_val("alarming", alarming, m_alarming);
   endtask

   task automatic cycle(input bit t, input bit bm, input bit bn, input bit bi);
      tick_1hz = t; btn_mode = bm; btn_next = bn; btn_inc = bi;
      @(posedge clk);
      model_step(t, bm, bn, bi);
      #1;
      tick_1hz = 1'b0; btn_mode = 1'b0; btn_next = 1'b0; btn_inc = 1'b0;
      check_outputs();
   endtask

   // kind: 0 mode, 1 next, 2 inc, 3 tick
   task automatic press(input int kind, input int n);
      for (int k = 0; k < n; k++) begin
         cycle(kind == 3, kind == 0, kind == 1, kind == 2);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      tick_1hz = 1'b0; btn_mode = 1'b0; btn_next = 1'b0; btn_inc = 1'b0;
      model_reset();
      #12;
      check_outputs();
      @(negedge clk);
      rst_n = 1'b1;

      // field editing and hour wrap
      press(0, 1);
      press(2, 3);
      check_val("hour_set3", cur_time[23:16], 8'd3);
      check_val("hour_flash_sel", hour_flash, 1'b1);
      press(1, 3);
      check_val("field_wrap", hour_flash, 1'b1);
      press(2, 26);
      check_val("hour_wrap", cur_time[23:16], 8'd5);

      // 23:59:59 rolls to midnight, which also matches the 00:00:00 alarm
      press(2, 18); press(1, 1); press(2, 59); press(1, 1); press(2, 59);
      check_val("set_235959", cur_time, 24'h173B3B);
      press(0, 2);
      press(3, 1);
      check_val("day_wrap", cur_time, 24'h000000);
      check_val("alarm_midnight", alarming, 1'b1);

      // cancel consumes the pulse
      press(2, 1);
      check_val("cancel_alarm", alarming, 1'b0);
      check_val("cancel_mode", mode, 2'd0);
      check_val("cancel_time", cur_time, 24'h000000);

      // alarm at 00:00:05, lasting three ticks
      press(0, 2); press(1, 2); press(2, 5);
      check_val("alarm_shown", cur_time, 24'h000005);
      press(0, 1);
      press(3, 4);
      check_val("alarm_early", alarming, 1'b0);
      press(3, 1);
      check_val("alarm_fire", alarming, 1'b1);
      check_val("alarm_fire_time", cur_time, 24'h000005);
      press(3, 2);
      check_val("alarm_hold", alarming, 1'b1);
      press(3, 1);
      check_val("alarm_expire", alarming, 1'b0);
      check_val("alarm_mode", mode, 2'd0);

      // re-arm for 00:00:09 then reset asynchronously mid-alarm
      press(0, 2); press(1, 2); press(2, 4); press(0, 1);
      press(3, 1);
      check_val("alarm_refire", alarming, 1'b1);
      #3 rst_n = 1'b0;
      #1;
      check_val("arst_time", cur_time, 24'h000000);
      check_val("arst_mode", mode, 2'd0);
      check_val("arst_flash", {hour_flash, minute_flash, second_flash}, 3'b000);
      check_val("arst_alarming", alarming, 1'b0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;

      // mode beats inc in the same cycle; ticks frozen in SET_TIME
      press(0, 1); press(2, 2);
      cycle(1'b0, 1'b1, 1'b0, 1'b1);
      check_val("prio_mode", mode, 2'd2);
      check_val("prio_alarm", cur_time, 24'h000000);
      press(0, 1);
      check_val("prio_time", cur_time, 24'h020000);
      press(0, 1);
      press(3, 3);
      check_val("frozen_time", cur_time, 24'h020000);
      press(0, 2);

      // random buttons and ticks
      for (int i = 0; i < 3000; i++) begin
         cycle($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
               $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0);
      end

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
